// File: rtl/seq_bit_serializer.sv
// ---------------------------------------------------------------------------
// seq_bit_serializer
//
// Parallel-to-serial stage that feeds the serial sequence detectors one bit
// per clock. A DATA_W-bit word is taken on a valid/ready handshake and is then
// presented on sout one bit per cycle. When in_valid is held high, words follow
// each other with no gap. Between words, sout is driven to IDLE_BIT.
//
// Parameters
//   DATA_W     word width in bits (>= 2)
//   MSB_FIRST  1: bit DATA_W-1 is sent first, 0: bit 0 is sent first
//   IDLE_BIT   level driven on sout when no word is being sent
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst          synchronous, active-high reset
//   in_data      parallel word, sampled only on accept
//   in_valid     upstream has a word
//   in_ready     block can accept (accept = in_valid & in_ready at an edge)
//   sout         serial bit
//   sout_valid   sout carries a data bit this cycle
//   frame_first  sout is the first transmitted bit of the word
//   frame_last   sout is the last transmitted bit of the word
// ---------------------------------------------------------------------------
module seq_bit_serializer #(
    parameter int DATA_W    = 4,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              sout,
    output logic              sout_valid,
    output logic              frame_first,
    output logic              frame_last
);

    localparam int              CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [DATA_W-1:0]   sreg;
    logic [DATA_W-1:0]   sreg_next;
    logic [DATA_W-1:0]   sreg_shifted;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_next;
    logic                out_bit;
    logic                accept;
    logic                on_last_bit;

    // The bit on sout always sits at the output end of the shift register.
    // Each shift moves the next bit to that end and fills the vacated end
    // with zero.
    always_comb begin
        if (MSB_FIRST) begin
            out_bit      = sreg[DATA_W-1];
            sreg_shifted = {sreg[DATA_W-2:0], 1'b0};
        end else begin
            out_bit      = sreg[0];
            sreg_shifted = {1'b0, sreg[DATA_W-1:1]};
        end
    end

    // A new word can be taken while idle, and also during the last bit of
    // the current word. Taking it during the last bit is what allows
    // back-to-back words with no gap. in_ready is held low during reset so
    // that no handshake completes in the same cycle that reset clears the
    // state.
    always_comb begin
        on_last_bit = (state == SHIFT) && (cnt == CNT_LAST);
        in_ready    = !rst && ((state == IDLE) || on_last_bit);
        accept      = in_valid && in_ready;
    end

    // Next-state logic. An accept always reloads the shift register and
    // restarts the bit index, whether it happens from IDLE or on the last
    // bit of a word.
    always_comb begin
        state_next = state;
        sreg_next  = sreg;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    sreg_next  = in_data;
                    cnt_next   = '0;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt != CNT_LAST) begin
                    sreg_next = sreg_shifted;
                    cnt_next  = cnt + CNT_W'(1);
                end else if (accept) begin
                    sreg_next = in_data;
                    cnt_next  = '0;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register. Reset takes priority and drops any word that is
    // part-way through.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            sreg  <= sreg_next;
            cnt   <= cnt_next;
        end
    end

    // The serial outputs depend only on registered state, so no input can
    // reach them combinationally.
    always_comb begin
        sout_valid  = (state == SHIFT);
        sout        = sout_valid ? out_bit : IDLE_BIT;
        frame_first = (state == SHIFT) && (cnt == '0);
        frame_last  = on_last_bit;
    end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// ---------------------------------------------------------------------------
// tb_seq_bit_serializer
//
// Three serializer instances share one clock and one reset:
//   u_dut  DATA_W=4, MSB first, idle level 0 (driven by the vector table)
//   u_lsb  DATA_W=4, LSB first, idle level 1
//   u_w8   DATA_W=8, MSB first, idle level 0
// Each vector row gives the inputs for one cycle and the outputs expected in
// that cycle, before the rising edge that ends the cycle.
// ---------------------------------------------------------------------------
module tb_seq_bit_serializer;

    logic       clk;
    logic       rst;

    logic [3:0] in_data_a;
    logic       in_valid_a;
    logic       in_ready_a;
    logic       sout_a;
    logic       sout_valid_a;
    logic       frame_first_a;
    logic       frame_last_a;

    logic [3:0] in_data_l;
    logic       in_valid_l;
    logic       in_ready_l;
    logic       sout_l;
    logic       sout_valid_l;
    logic       frame_first_l;
    logic       frame_last_l;

    logic [7:0] in_data_w;
    logic       in_valid_w;
    logic       in_ready_w;
    logic       sout_w;
    logic       sout_valid_w;
    logic       frame_first_w;
    logic       frame_last_w;

    int checks;
    int errors;

    // Each row holds the inputs for one cycle and the outputs expected in
    // that cycle. The expected bits are {sout, sout_valid, frame_first,
    // frame_last, in_ready}.
    typedef struct {
        logic       rst;
        logic       valid;
        logic [3:0] data;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[$];

    seq_bit_serializer #(.DATA_W(4), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data_a),
        .in_valid    (in_valid_a),
        .in_ready    (in_ready_a),
        .sout        (sout_a),
        .sout_valid  (sout_valid_a),
        .frame_first (frame_first_a),
        .frame_last  (frame_last_a)
    );

    seq_bit_serializer #(.DATA_W(4), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_lsb (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data_l),
        .in_valid    (in_valid_l),
        .in_ready    (in_ready_l),
        .sout        (sout_l),
        .sout_valid  (sout_valid_l),
        .frame_first (frame_first_l),
        .frame_last  (frame_last_l)
    );

    seq_bit_serializer #(.DATA_W(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_w8 (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data_w),
        .in_valid    (in_valid_w),
        .in_ready    (in_ready_w),
        .sout        (sout_w),
        .sout_valid  (sout_valid_w),
        .frame_first (frame_first_w),
        .frame_last  (frame_last_w)
    );

    // Free-running clock with a 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(input logic r, input logic v, input logic [3:0] d,
                                input logic [4:0] e);
        vec_t t;
        t.rst   = r;
        t.valid = v;
        t.data  = d;
        t.exp   = e;
        return t;
    endfunction

    task automatic applyStimulus(input vec_t v);
        rst        = v.rst;
        in_valid_a = v.valid;
        in_data_a  = v.data;
    endtask

    task automatic checkOutput(input string name, input int idx, input logic act,
                               input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s step %0d: got %b expected %b", name, idx, act, exp);
        end
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    // Expected transmit order of each hand-checked word, first bit at the
    // left.
    logic [3:0] lsb_order;
    logic [7:0] w8_order;

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        in_valid_a = 1'b0;
        in_data_a  = 4'h0;
        in_valid_l = 1'b0;
        in_data_l  = 4'h0;
        in_valid_w = 1'b0;
        in_data_w  = 8'h00;

        // Reset still asserted: the instance is idle and in_ready is forced low.
        vecs.push_back(mk(1, 0, 4'h0, 5'b00000));
        // Five idle cycles after reset is released.
        for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 0, 4'h0, 5'b00001));
        // 1010, MSB first, then in_valid drops.
        vecs.push_back(mk(0, 1, 4'b1010, 5'b00001));
        vecs.push_back(mk(0, 0, 4'h0,    5'b11100));
        vecs.push_back(mk(0, 0, 4'h0,    5'b01000));
        vecs.push_back(mk(0, 0, 4'h0,    5'b11000));
        vecs.push_back(mk(0, 0, 4'h0,    5'b01011));
        vecs.push_back(mk(0, 0, 4'h0,    5'b00001));
        // 1100 followed by 0011 with no gap between the words.
        vecs.push_back(mk(0, 1, 4'b1100, 5'b00001));
        vecs.push_back(mk(0, 1, 4'b0011, 5'b11100));
        vecs.push_back(mk(0, 1, 4'b0011, 5'b11000));
        vecs.push_back(mk(0, 1, 4'b0011, 5'b01000));
        vecs.push_back(mk(0, 1, 4'b0011, 5'b01011));
        vecs.push_back(mk(0, 0, 4'h0,    5'b01100));
        vecs.push_back(mk(0, 0, 4'h0,    5'b01000));
        vecs.push_back(mk(0, 0, 4'h0,    5'b11000));
        vecs.push_back(mk(0, 0, 4'h0,    5'b11011));
        vecs.push_back(mk(0, 0, 4'h0,    5'b00001));
        // 0110 in flight while F is offered; F is taken only on frame_last.
        vecs.push_back(mk(0, 1, 4'b0110, 5'b00001));
        vecs.push_back(mk(0, 1, 4'hF,    5'b01100));
        vecs.push_back(mk(0, 1, 4'hF,    5'b11000));
        vecs.push_back(mk(0, 1, 4'hF,    5'b11000));
        vecs.push_back(mk(0, 1, 4'hF,    5'b01011));
        vecs.push_back(mk(0, 0, 4'h0,    5'b11100));
        vecs.push_back(mk(0, 0, 4'h0,    5'b11000));
        vecs.push_back(mk(0, 0, 4'h0,    5'b11000));
        vecs.push_back(mk(0, 0, 4'h0,    5'b11011));
        vecs.push_back(mk(0, 0, 4'h0,    5'b00001));
        // 1111 with reset during bit 1, then 1001 sent cleanly.
        vecs.push_back(mk(0, 1, 4'b1111, 5'b00001));
        vecs.push_back(mk(0, 0, 4'h0,    5'b11100));
        vecs.push_back(mk(1, 0, 4'h0,    5'b11000));
        vecs.push_back(mk(0, 0, 4'h0,    5'b00001));
        vecs.push_back(mk(0, 1, 4'b1001, 5'b00001));
        vecs.push_back(mk(0, 0, 4'h0,    5'b11100));
        vecs.push_back(mk(0, 0, 4'h0,    5'b01000));
        vecs.push_back(mk(0, 0, 4'h0,    5'b01000));
        vecs.push_back(mk(0, 0, 4'h0,    5'b11011));
        vecs.push_back(mk(0, 0, 4'h0,    5'b00001));

        stepClock();
        stepClock();

        // Table-driven run on the 4-bit MSB-first instance.
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput("sout",        i, sout_a,        vecs[i].exp[4]);
            checkOutput("sout_valid",  i, sout_valid_a,  vecs[i].exp[3]);
            checkOutput("frame_first", i, frame_first_a, vecs[i].exp[2]);
            checkOutput("frame_last",  i, frame_last_a,  vecs[i].exp[1]);
            checkOutput("in_ready",    i, in_ready_a,    vecs[i].exp[0]);
            stepClock();
        end
        rst        = 1'b0;
        in_valid_a = 1'b0;

        // LSB-first instance with idle level 1: 0001 is sent as 1,0,0,0.
        lsb_order  = 4'b1000;
        in_valid_l = 1'b1;
        in_data_l  = 4'b0001;
        #1;
        checkOutput("lsb_idle_sout",  0, sout_l,       1'b1);
        checkOutput("lsb_idle_valid", 0, sout_valid_l, 1'b0);
        checkOutput("lsb_ready",      0, in_ready_l,   1'b1);
        stepClock();
        in_valid_l = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            checkOutput("lsb_sout",  k, sout_l,       lsb_order[3-k]);
            checkOutput("lsb_valid", k, sout_valid_l, 1'b1);
            checkOutput("lsb_first", k, frame_first_l, (k == 0));
            checkOutput("lsb_last",  k, frame_last_l,  (k == 3));
            stepClock();
        end
        #1;
        checkOutput("lsb_end_sout",  0, sout_l,       1'b1);
        checkOutput("lsb_end_valid", 0, sout_valid_l, 1'b0);

        // 8-bit MSB-first instance: A5 is sent as 1,0,1,0,0,1,0,1.
        w8_order   = 8'b1010_0101;
        in_valid_w = 1'b1;
        in_data_w  = 8'hA5;
        #1;
        checkOutput("w8_ready", 0, in_ready_w, 1'b1);
        stepClock();
        in_valid_w = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            checkOutput("w8_sout",  k, sout_w,        w8_order[7-k]);
            checkOutput("w8_valid", k, sout_valid_w,  1'b1);
            checkOutput("w8_first", k, frame_first_w, (k == 0));
            checkOutput("w8_last",  k, frame_last_w,  (k == 7));
            checkOutput("w8_ready", k, in_ready_w,    (k == 7));
            stepClock();
        end
        #1;
        checkOutput("w8_end_sout",  0, sout_w,       1'b0);
        checkOutput("w8_end_valid", 0, sout_valid_w, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
